// File: rtl/hc595_shifter.sv
// hc595_shifter: serializes one byte into a 74HC595 (MSB first), then pulses
// RCLK to latch it. SRCLK runs at CLK_DIV system cycles per half-period.
// Request handshake: a request is taken on any rising edge where o_ready=1
// and i_enable=1; o_ready drops on the following cycle and stays low until
// the latch phase has finished. i_enable is ignored while o_ready=0.
// All outputs, including the o_state debug view, come straight from flops.
module hc595_shifter #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_enable,
    output logic       o_ready,
    output logic       o_ser,
    output logic       o_srclk,
    output logic       o_rclk,
    output logic       o_oe_n,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shreg, shreg_d;
    logic             phase_done;

    logic ready_d, ser_d, srclk_d, rclk_d, oe_n_d;

    assign phase_done = (cnt == CNT_LAST);
    assign o_state    = state;

    // State register plus the datapath that moves with it (divider, index, byte).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
        end
    end

    // Next-state logic: each timed phase lasts CLK_DIV cycles, then advances.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shreg_d = shreg;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    shreg_d = i_data;
                    idx_d   = 3'd7;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    if (idx != 3'd0) begin
                        idx_d   = idx - 3'd1;
                        state_d = SETUP;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Divider restarts on every state entry so no phase can be cut short.
        if (state_d != state || state_d == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    // Output decode from the upcoming state, so registered outputs line up with it.
    always_comb begin
        ready_d = (state_d == IDLE);
        srclk_d = (state_d == SHIFT_HI);
        rclk_d  = (state_d == LATCH);
        ser_d   = 1'b0;
        if (state_d == SETUP || state_d == SHIFT_HI) begin
            ser_d = shreg_d[idx_d];
        end
        // Outputs of the 595 stay disabled until a full byte has been latched.
        oe_n_d = o_oe_n;
        if (state == LATCH && state_d == IDLE) begin
            oe_n_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ready <= 1'b1;
            o_ser   <= 1'b0;
            o_srclk <= 1'b0;
            o_rclk  <= 1'b0;
            o_oe_n  <= 1'b1;
        end else begin
            o_ready <= ready_d;
            o_ser   <= ser_d;
            o_srclk <= srclk_d;
            o_rclk  <= rclk_d;
            o_oe_n  <= oe_n_d;
        end
    end

endmodule

// File: tb/tb_hc595_shifter.sv
// tb_hc595_shifter: two instances (CLK_DIV=1 and CLK_DIV=4) driven with
// directed and random transfers; a behavioural 74HC595 model and phase
// timers watch the pins and are compared with what the byte stream implies.
module tb_hc595_shifter;

    logic       clk;
    logic       rst_n [2];
    logic [7:0] data  [2];
    logic       en    [2];
    logic       ready [2];
    logic       ser   [2];
    logic       srclk [2];
    logic       rclk  [2];
    logic       oe_n  [2];
    logic [1:0] st    [2];

    int errors = 0;
    int checks = 0;

    // Reference model state: bytes expected to be latched, in order.
    logic [7:0] exp_q [$];
    logic       oe_exp [2];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    hc595_shifter #(.CLK_DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_data(data[0]), .i_enable(en[0]),
        .o_ready(ready[0]), .o_ser(ser[0]), .o_srclk(srclk[0]), .o_rclk(rclk[0]),
        .o_oe_n(oe_n[0]), .o_state(st[0])
    );

    hc595_shifter #(.CLK_DIV(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_data(data[1]), .i_enable(en[1]),
        .o_ready(ready[1]), .o_ser(ser[1]), .o_srclk(srclk[1]), .o_rclk(rclk[1]),
        .o_oe_n(oe_n[1]), .o_state(st[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // ---------------- pin monitors / 595 model ----------------
    logic [7:0] sh595 [2];
    logic [7:0] lat_log [2][32];
    int lat_cnt [2];
    int srclk_rises [2];
    int rclk_rises [2];
    int low_run [2];
    int last_low_run [2];
    int hi_run [2], lo_run [2];
    int hi_min [2], hi_max [2], lo_min [2], lo_max [2];
    logic p_srclk [2], p_rclk [2], p_ready [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            sh595[k] = 8'h00; lat_cnt[k] = 0; srclk_rises[k] = 0; rclk_rises[k] = 0;
            low_run[k] = 0; last_low_run[k] = 0; hi_run[k] = 0; lo_run[k] = 0;
            hi_min[k] = 1000000; hi_max[k] = 0; lo_min[k] = 1000000; lo_max[k] = 0;
            p_srclk[k] = 1'b0; p_rclk[k] = 1'b0; p_ready[k] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ready[k] && p_ready[k]) begin
                hi_min[k] = 1000000; hi_max[k] = 0;
                lo_min[k] = 1000000; lo_max[k] = 0;
                hi_run[k] = 0; lo_run[k] = 0;
            end
            if (srclk[k] && !p_srclk[k]) begin
                sh595[k] = {sh595[k][6:0], ser[k]};
                srclk_rises[k]++;
                if (lo_run[k] < lo_min[k]) lo_min[k] = lo_run[k];
                if (lo_run[k] > lo_max[k]) lo_max[k] = lo_run[k];
                lo_run[k] = 0;
            end
            if (!srclk[k] && p_srclk[k]) begin
                if (hi_run[k] < hi_min[k]) hi_min[k] = hi_run[k];
                if (hi_run[k] > hi_max[k]) hi_max[k] = hi_run[k];
                hi_run[k] = 0;
            end
            if (srclk[k]) hi_run[k]++;
            if (!ready[k] && !srclk[k] && !rclk[k]) lo_run[k]++;
            if (rclk[k] && !p_rclk[k]) begin
                rclk_rises[k]++;
                lat_log[k][lat_cnt[k] % 32] = sh595[k];
                lat_cnt[k]++;
            end
            if (!ready[k]) begin
                low_run[k]++;
            end else if (low_run[k] > 0) begin
                last_low_run[k] = low_run[k];
                low_run[k] = 0;
            end
            p_srclk[k] = srclk[k];
            p_rclk[k]  = rclk[k];
            p_ready[k] = ready[k];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, div_of(k), obs, expv);
        end
    endtask

    task automatic chk_reset_pins(input string tag, input int k);
        chk({tag, "_ready"}, k, 32'(ready[k]), 32'd1);
        chk({tag, "_ser"},   k, 32'(ser[k]),   32'd0);
        chk({tag, "_srclk"}, k, 32'(srclk[k]), 32'd0);
        chk({tag, "_rclk"},  k, 32'(rclk[k]),  32'd0);
        chk({tag, "_oe_n"},  k, 32'(oe_n[k]),  32'd1);
    endtask

    // Wait (bounded) for o_ready to come back high; returns at a negedge.
    task automatic wait_ready(input int k, input string tag);
        int n;
        bit seen;
        seen = 0;
        n = 0;
        while (n < 17 * div_of(k) + 20) begin
            @(negedge clk);
            if (ready[k]) begin
                seen = 1;
                break;
            end
            n++;
        end
        chk({tag, "_timeout"}, k, 32'(seen), 32'd1);
    endtask

    // One request pulse, optional mid-transfer poke, then model comparisons.
    task automatic xfer(input int k, input logic [7:0] d, input bit poke);
        int s0, r0;
        logic [7:0] expb;
        s0 = srclk_rises[k];
        r0 = rclk_rises[k];
        @(negedge clk);
        chk("ready_idle", k, 32'(ready[k]), 32'd1);
        data[k] = d;
        en[k] = 1'b1;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        en[k] = 1'b0;
        data[k] = 8'($urandom);
        @(negedge clk);
        chk("ready_fall", k, 32'(ready[k]), 32'd0);
        chk("oe_during", k, 32'(oe_n[k]), 32'(oe_exp[k]));
        if (poke) begin
            repeat (3) @(negedge clk);
            data[k] = ~d;
            en[k] = 1'b1;
            @(negedge clk);
            en[k] = 1'b0;
        end
        wait_ready(k, "done");
        repeat (6) @(negedge clk);
        #1;
        oe_exp[k] = 1'b0;
        expb = exp_q.pop_front();
        chk("ready_low_len", k, 32'(last_low_run[k]), 32'(17 * div_of(k)));
        chk("srclk_rises", k, 32'(srclk_rises[k] - s0), 32'd8);
        chk("rclk_rises", k, 32'(rclk_rises[k] - r0), 32'd1);
        chk("latched", k, 32'(lat_log[k][(lat_cnt[k] - 1) % 32]), 32'(expb));
        chk("oe_after", k, 32'(oe_n[k]), 32'd0);
        chk("ready_stays", k, 32'(ready[k]), 32'd1);
        chk("hi_phase_min", k, 32'(hi_min[k]), 32'(div_of(k)));
        chk("hi_phase_max", k, 32'(hi_max[k]), 32'(div_of(k)));
        chk("lo_phase_min", k, 32'(lo_min[k]), 32'(div_of(k)));
        chk("lo_phase_max", k, 32'(lo_max[k]), 32'(div_of(k)));
    endtask

    // i_enable held high across two bytes.
    task automatic back_to_back(input int k, input logic [7:0] d0, input logic [7:0] d1);
        int l0, hi, n;
        l0 = lat_cnt[k];
        @(negedge clk);
        data[k] = d0;
        en[k] = 1'b1;
        @(negedge clk);
        chk("b2b_accept0", k, 32'(ready[k]), 32'd0);
        data[k] = d1;
        hi = 0;
        n = 0;
        while (n < 17 * div_of(k) + 20) begin
            @(negedge clk);
            if (ready[k]) hi++;
            else if (hi > 0) break;
            n++;
        end
        en[k] = 1'b0;
        chk("b2b_ready_gap", k, 32'(hi), 32'd1);
        wait_ready(k, "b2b_done");
        repeat (4) @(negedge clk);
        #1;
        oe_exp[k] = 1'b0;
        chk("b2b_count", k, 32'(lat_cnt[k] - l0), 32'd2);
        chk("b2b_first", k, 32'(lat_log[k][l0 % 32]), 32'(d0));
        chk("b2b_second", k, 32'(lat_log[k][(l0 + 1) % 32]), 32'(d1));
    endtask

    // Reset asserted after the 3rd SRCLK rise, with i_enable high during reset.
    task automatic reset_mid(input int k);
        int s0, r0, n;
        s0 = srclk_rises[k];
        r0 = rclk_rises[k];
        @(negedge clk);
        data[k] = 8'($urandom);
        en[k] = 1'b1;
        @(posedge clk);
        #1;
        en[k] = 1'b0;
        n = 0;
        while (n < 17 * div_of(k) + 20) begin
            @(negedge clk);
            #1;
            if (srclk_rises[k] - s0 >= 3) break;
            n++;
        end
        chk("rst_mid_rises", k, 32'(srclk_rises[k] - s0), 32'd3);
        rst_n[k] = 1'b0;
        en[k] = 1'b1;
        @(negedge clk);
        chk_reset_pins("rst_mid", k);
        @(negedge clk);
        rst_n[k] = 1'b1;
        en[k] = 1'b0;
        oe_exp[k] = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rst_no_rclk", k, 32'(rclk_rises[k] - r0), 32'd0);
        chk("rst_no_more_srclk", k, 32'(srclk_rises[k] - s0), 32'd3);
        chk("rst_idle_ready", k, 32'(ready[k]), 32'd1);
        chk("rst_oe_n", k, 32'(oe_n[k]), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            data[k] = 8'h00;
            en[k] = 1'b0;
            oe_exp[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk_reset_pins("reset", k);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) chk_reset_pins("post_reset_idle", k);

        // Basic bytes on each divider setting.
        xfer(0, 8'h55, 1'b0);
        xfer(1, 8'hAA, 1'b0);

        // Data change and i_enable pulse during a transfer.
        xfer(1, 8'h3C, 1'b1);
        xfer(0, 8'hC3, 1'b1);

        // i_enable held high across two bytes.
        back_to_back(0, 8'h55, 8'hAA);
        back_to_back(1, 8'h55, 8'hAA);

        // Reset mid-transfer, then a normal transfer.
        reset_mid(1);
        xfer(1, 8'h96, 1'b0);
        reset_mid(0);
        xfer(0, 8'h69, 1'b0);

        // Random bytes, random instance, random gaps and pokes.
        for (int i = 0; i < 10; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(k, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        chk("exp_q_empty", 0, 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
